// File: rtl/core_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with a single-cycle path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating one bit per cycle, XLEN cycles
// DONE  | result in o_res, o_valid pulses
module core_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_num1u,
  input  logic [XLEN-1:0] i_num2u,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_funct3;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_res;

  logic            w_s1, w_s2, w_neg1, w_neg2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_fast_res;

  // Sign handling is decided at accept time; the iteration only ever sees magnitudes.
  assign w_s1   = (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
                  (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
  assign w_s2   = (i_funct3 == 3'b001) | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
  assign w_neg1 = w_s1 & i_num1u[XLEN-1];
  assign w_neg2 = w_s2 & i_num2u[XLEN-1];
  assign w_mag1 = w_neg1 ? -i_num1u : i_num1u;
  assign w_mag2 = w_neg2 ? -i_num2u : i_num2u;

  assign w_div0 = i_funct3[2] & (i_num2u == '0);
  assign w_ovf  = i_funct3[2] & ~i_funct3[0] & (i_num1u == MIN_INT) & (i_num2u == '1);
  assign w_fast = w_div0 | w_ovf;
  assign w_fast_res = w_div0 ? (i_funct3[1] ? i_num1u : '1)
                             : (i_funct3[1] ? '0 : MIN_INT);

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_full, w_mul_fin;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub, w_rem_next, w_quo_next, w_quo_fin, w_rem_fin;
  logic [XLEN-1:0]   w_calc_res;

  // r_hi:r_lo is the running product (multiply) or remainder:quotient (divide).
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_full = {w_mul_sum, r_lo[XLEN-1:1]};
  assign w_mul_fin  = r_neg_q ? -w_mul_full : w_mul_full;
  assign w_mul_res  = (r_funct3[1:0] == 2'b00) ? w_mul_fin[XLEN-1:0]
                                               : w_mul_fin[2*XLEN-1:XLEN];

  assign w_shift    = {r_hi, r_lo[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_a});
  assign w_sub      = w_shift[XLEN-1:0] - r_a;
  assign w_rem_next = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_next = {r_lo[XLEN-2:0], w_ge};
  assign w_quo_fin  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_rem_fin  = r_neg_r ? -w_rem_next : w_rem_next;

  assign w_calc_res = r_funct3[2] ? (r_funct3[1] ? w_rem_fin : w_quo_fin) : w_mul_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res    <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_funct3 <= i_funct3;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= i_funct3[2] ? w_mag1 : w_mag2;
            r_a      <= i_funct3[2] ? w_mag2 : w_mag1;
            if (w_fast) begin
              r_res   <= w_fast_res;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_funct3[2]) begin
            r_hi <= w_rem_next;
            r_lo <= w_quo_next;
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_res   <= w_calc_res;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE) & ~i_flush;
  assign o_res   = r_res;

endmodule

// File: tb/tb_core_muldiv.sv
// Bench for core_muldiv: directed corner cases plus random ops checked against an
// arithmetic reference model; a second XLEN=64 instance covers the wide build.
module tb_core_muldiv;
  localparam int XL = 32;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_flush = 1'b0;
  logic [2:0]  i_funct3 = 3'b0;
  logic [31:0] i_num1u = '0, i_num2u = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_res;

  logic        v64 = 1'b0, flush64 = 1'b0;
  logic [2:0]  f64 = 3'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        ready64, valid64;
  logic [63:0] res64;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_funct3(i_funct3),
    .i_num1u(i_num1u), .i_num2u(i_num2u), .i_flush(i_flush),
    .o_ready(o_ready), .o_valid(o_valid), .o_res(o_res)
  );

  core_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .i_valid(v64), .i_funct3(f64),
    .i_num1u(a64), .i_num2u(b64), .i_flush(flush64),
    .o_ready(ready64), .o_valid(valid64), .o_res(res64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, b);
    longint sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = sa / sb;
        return r[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, b);
    return f3[2] && ((b == 0) || (!f3[0] && a == MIN32 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN32;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Starts at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, b, input string tag);
    int lat, ready_bad, exp_lat;
    logic [31:0] exp;
    exp     = ref_model(f3, a, b);
    exp_lat = is_fast(f3, a, b) ? 1 : XL + 1;
    i_valid = 1'b1; i_funct3 = f3; i_num1u = a; i_num2u = b;
    @(posedge clk); #1;
    i_valid = 1'b0; i_funct3 = 3'($urandom); i_num1u = $urandom; i_num2u = $urandom;
    lat = 0; ready_bad = 0;
    for (int n = 1; n <= XL + 8; n++) begin
      @(negedge clk);
      if (o_ready !== 1'b0) ready_bad++;
      if (o_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, " res"}, {32'h0, o_res}, {32'h0, exp});
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " ready low"}, 64'(ready_bad), 64'd0);
    @(negedge clk);
    chk({tag, " idle/hold"}, {30'h0, o_ready, o_valid, o_res}, {30'h0, 2'b10, exp});
  endtask

  initial begin
    int bad, lat;
    logic [2:0] f3;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    chk("reset state", {31'h0, o_ready, o_valid, o_res}, {31'h0, 2'b10, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul");
    chk("mul const", {32'h0, o_res}, 64'hFFFF_FFEB);
    do_op(3'b001, MIN32, MIN32, "mulh");
    chk("mulh const", {32'h0, o_res}, 64'h4000_0000);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    chk("mulhu const", {32'h0, o_res}, 64'hFFFF_FFFE);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div const", {32'h0, o_res}, 64'hFFFF_FFFD);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem");
    do_op(3'b101, 32'd100, 32'd7, "divu");
    do_op(3'b111, 32'd100, 32'd7, "remu");
    chk("remu const", {32'h0, o_res}, 64'd2);
    do_op(3'b101, 32'd5, 32'd0, "divu0");
    do_op(3'b111, 32'd5, 32'd0, "remu0");
    chk("remu0 const", {32'h0, o_res}, 64'd5);
    do_op(3'b100, MIN32, 32'hFFFF_FFFF, "div ovf");
    do_op(3'b110, MIN32, 32'hFFFF_FFFF, "rem ovf");

    // flush mid-divide, then back-to-back accept
    i_valid = 1'b1; i_funct3 = 3'b100; i_num1u = 32'd1000; i_num2u = 32'd7;
    @(posedge clk); #1 i_valid = 1'b0;
    bad = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) bad++;
    end
    @(negedge clk);
    i_flush = 1'b1;
    chk("flush pre-valid", 64'(bad), 64'd0);
    @(posedge clk); #1 i_flush = 1'b0;
    @(negedge clk);
    chk("flush ready T+11", {62'h0, o_ready, o_valid}, 64'h2);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div after flush");

    // flush during DONE suppresses the pulse
    i_valid = 1'b1; i_funct3 = 3'b101; i_num1u = 32'd5; i_num2u = 32'd0;
    @(posedge clk); #1 i_valid = 1'b0; i_flush = 1'b1;
    @(negedge clk);
    chk("flush done valid", {63'h0, o_valid}, 64'h0);
    @(posedge clk); #1 i_flush = 1'b0;
    @(negedge clk);
    chk("after done flush", {62'h0, o_ready, o_valid}, 64'h2);

    // flush with request in IDLE drops it
    i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'b000; i_num1u = 32'd3; i_num2u = 32'd3;
    @(posedge clk); #1 i_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    chk("drop idle 1", {62'h0, o_ready, o_valid}, 64'h2);
    @(negedge clk);
    chk("drop idle 2", {62'h0, o_ready, o_valid}, 64'h2);

    // reset mid-multiply
    i_valid = 1'b1; i_funct3 = 3'b000; i_num1u = 32'd3; i_num2u = 32'd5;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid-op", {31'h0, o_ready, o_valid, o_res}, {31'h0, 2'b10, 32'h0});
    bad = 0;
    for (int n = 0; n < XL + 4; n++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) bad++;
    end
    chk("rst no valid", 64'(bad), 64'd0);

    for (int k = 0; k < 40; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f3, a, b, "rand");
    end

    // XLEN=64 build
    v64 = 1'b1; f64 = 3'b011; a64 = '1; b64 = '1;
    @(posedge clk); #1 v64 = 1'b0; a64 = '0; b64 = '0;
    lat = 0;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (valid64 === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("mulhu64 res", res64, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulhu64 latency", 64'(lat), 64'd65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
